chipset_bank_ctrl: RTL and testbench
====================================

Name: chipset_bank_ctrl

Overview:
- Parametrised chipset control block for the 8086 board. Replaces the single 2-bit bank register with NUM_WINDOWS independently banked memory windows, an extended physical address and a programmable wait-state generator driving READY.
- Sits between the latched CPU address/strobes and the RAM decode. Its registers are programmed through an 8-port I/O window.
- All logic is synchronous to the 60 MHz board clock.

Parameters:
- IO_BASE, 10'h030, base of the 8-port register window (the low 3 bits must be 0).
- NUM_WINDOWS, 4, number of banked windows (1..6).
- WIN_BITS, 16, log2 of the window size in bytes.
- WIN_BASE, 20'h80000, start of window 0; windows are contiguous.
- BANK_BITS, 6, width of each bank register; PHYS_BITS = BANK_BITS + WIN_BITS, which must be at least 20.
- DEFAULT_WS, 4'd0, reset value of the wait-state register.

Ports:
- clk  in  1  board clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ADDR  in  20  latched CPU address.
- M_IO  in  1  1 = memory cycle, 0 = I/O cycle.
- RD  in  1  active-low read strobe.
- WR  in  1  active-low write strobe.
- ALE  in  1  address latch enable, active high.
- DATA_IN  in  8  low data byte from the CPU side.
- DATA_OUT  out  8  register readback data.
- DATA_OE  out  1  DATA_OUT drive enable.
- PHYS_ADDR  out  PHYS_BITS  translated physical address.
- BANK_HIT  out  1  current memory address lies in a mapped window.
- READY  out  1  wait-state ready to the clock generator, active high.

Behaviour:
- Reset state: all outputs 0 except READY=1.
- Reset register values:
  - bank_reg[i] = i (identity map).
  - ws_reg = DEFAULT_WS.
  - ctrl_reg = 0.
  - ws_cnt = 0.
- RESET_N low mid-operation:
  - clears everything immediately; READY goes to 1 without waiting for a clock.
  - any partial write is discarded.
- Register map (offset = ADDR[2:0], valid only when M_IO=0 and ADDR[9:3] = IO_BASE[9:3]):
  - offsets 0..NUM_WINDOWS-1: bank_reg, BANK_BITS wide.
  - offset NUM_WINDOWS: ws_reg[3:0].
  - offset NUM_WINDOWS+1: ctrl_reg[0] = map_en.
  - unused offsets: writes ignored, reads return 8'hFF.
  - bits above a register's width: reads return 0, writes are dropped.
- Write path:
  - WR passes through a 2-flop synchroniser; a falling edge of the synchronised WR is a commit.
  - On commit, if the address is selected, DATA_IN is written on that clock.
  - Exactly one write per strobe; commit latency is 3 clk after WR falls.
  - WR held low for many cycles still produces a single write.
- Read path:
  - DATA_OE = selected & ~RD, registered (1 clk latency).
  - DATA_OUT is registered from the mux in the same cycle.
- Translation (combinational from ADDR):
  - Window index = (ADDR - WIN_BASE) >> WIN_BITS.
  - A hit requires M_IO=1, map_en=1 and index < NUM_WINDOWS.
  - On a hit: BANK_HIT=1 and PHYS_ADDR = {bank_reg[idx], ADDR[WIN_BITS-1:0]}.
  - Otherwise: BANK_HIT=0 and PHYS_ADDR = zero-extended ADDR.
  - ADDR below WIN_BASE is never a hit; there is no wrap-around.
- Wait-state state machine, states IDLE and WAIT:
  - ALE is synchronised with 2 flops; a falling edge of the synchronised ALE with BANK_HIT=1 and ws_reg != 0 loads ws_cnt = ws_reg, drives READY=0 and enters WAIT.
  - In WAIT, ws_cnt decrements each clk; when it reaches 0, READY=1 and the machine returns to IDLE. READY is low for exactly ws_reg clocks.
  - ws_reg = 0 or a miss: READY stays 1.
  - A new qualifying ALE edge while in WAIT reloads ws_cnt (restart).
  - A write to ws_reg in the same clk as a load: the load uses the old value.
- A bank_reg write takes effect on PHYS_ADDR in the cycle after the commit.

Optional Feature:
- Macro: CHIPSET_READBACK_EN.
- Defined: register reads work as described above.
- Undefined: the read mux and DATA_OE logic are removed; DATA_OE is tied to 0 and DATA_OUT to 8'hFF. Writes and translation are unchanged.

Test Plan:
- Reset, then read all offsets with readback enabled → bank regs read 0,1,2,3; offset 4 reads 0; offset 5 reads 0; offsets 6 and 7 read FF. READY=1.
- Write 6'h2A to offset 1 and 1 to offset 5, then ADDR=20'h9ABCD, M_IO=1 → BANK_HIT=1 and PHYS_ADDR=22'h2AABCD. ADDR=20'hC0000 → BANK_HIT=0 and PHYS_ADDR=22'h0C0000.
- Set ws_reg=3, then an ALE pulse at ADDR=20'h80010 → READY low for exactly 3 clk. Same test at ADDR=20'h10000 → READY never drops.
- Hold WR low for 20 clk on offset 0 with DATA_IN changing mid-strobe → exactly one write, capturing the value present 3 clk after WR fell.
- Assert RESET_N low during WAIT with ws_cnt=5 → READY=1 asynchronously; bank_reg back to identity; map_en=0.
- With ws_reg=2, a second ALE edge 1 clk into WAIT → READY stays low for 2 further clk after the second edge.

Source files
------------

// File: rtl/chipset_bank_ctrl.sv
//------------------------------------------------------------------------------
// chipset_bank_ctrl : banked memory windows, physical address extension and
//                     wait-state READY generator for the 8086 board.
// Optional macro CHIPSET_READBACK_EN enables register readback.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module chipset_bank_ctrl #(
  parameter logic [9:0]  IO_BASE     = 10'h030,
  parameter int          NUM_WINDOWS = 4,
  parameter int          WIN_BITS    = 16,
  parameter logic [19:0] WIN_BASE    = 20'h80000,
  parameter int          BANK_BITS   = 6,
  parameter logic [3:0]  DEFAULT_WS  = 4'd0,
  localparam int         PHYS_BITS   = BANK_BITS + WIN_BITS
) (
  input  logic                 clk,
  input  logic                 RESET_N,
  input  logic [19:0]          ADDR,
  input  logic                 M_IO,
  input  logic                 RD,
  input  logic                 WR,
  input  logic                 ALE,
  input  logic [7:0]           DATA_IN,
  output logic [7:0]           DATA_OUT,
  output logic                 DATA_OE,
  output logic [PHYS_BITS-1:0] PHYS_ADDR,
  output logic                 BANK_HIT,
  output logic                 READY
);

  localparam logic [2:0] OFF_WS   = 3'(NUM_WINDOWS);
  localparam logic [2:0] OFF_CTRL = 3'(NUM_WINDOWS + 1);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [2:0]            wr_sync_q, wr_sync_d;
  logic [2:0]            ale_sync_q, ale_sync_d;
  logic [BANK_BITS-1:0]  bank_q [NUM_WINDOWS];
  logic [BANK_BITS-1:0]  bank_d [NUM_WINDOWS];
  logic [3:0]            ws_q, ws_d;
  logic                  map_en_q, map_en_d;
  logic [3:0]            ws_cnt_q, ws_cnt_d;
  logic                  ready_q, ready_d;

  logic                  commit;
  logic                  ale_fall;
  logic                  reg_sel;
  logic [2:0]            offset;
  logic [BANK_BITS-1:0]  wdata_bank;
  logic [19:0]           win_idx;
  logic [BANK_BITS-1:0]  bank_sel;
  logic                  bank_hit;
  logic                  ws_load;

  // Stage 2 is the synchronised strobe; stage 3 only remembers it for edge detection.
  always_comb begin
    wr_sync_d  = {wr_sync_q[1:0], WR};
    ale_sync_d = {ale_sync_q[1:0], ALE};
    commit     = wr_sync_q[2] & ~wr_sync_q[1];
    ale_fall   = ale_sync_q[2] & ~ale_sync_q[1];
    reg_sel    = ~M_IO & (ADDR[9:3] == IO_BASE[9:3]);
    offset     = ADDR[2:0];
    wdata_bank = BANK_BITS'(DATA_IN);
  end

  always_comb begin
    bank_d   = bank_q;
    ws_d     = ws_q;
    map_en_d = map_en_q;
    if (commit && reg_sel) begin
      for (int i = 0; i < NUM_WINDOWS; i++) begin
        if (offset == 3'(i)) bank_d[i] = wdata_bank;
      end
      if (offset == OFF_WS)   ws_d     = DATA_IN[3:0];
      if (offset == OFF_CTRL) map_en_d = DATA_IN[0];
    end
  end

  // The subtraction wraps below WIN_BASE, so the explicit compare blocks wrap-around hits.
  always_comb begin
    win_idx  = 20'((ADDR - WIN_BASE) >> WIN_BITS);
    bank_sel = '0;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (win_idx == 20'(i)) bank_sel = bank_q[i];
    end
    bank_hit = M_IO & map_en_q & (ADDR >= WIN_BASE) & (win_idx < 20'(NUM_WINDOWS));
    if (bank_hit) PHYS_ADDR = {bank_sel, ADDR[WIN_BITS-1:0]};
    else          PHYS_ADDR = PHYS_BITS'(ADDR);
    BANK_HIT = bank_hit;
  end

  always_comb begin
    state_d  = state_q;
    ws_cnt_d = ws_cnt_q;
    ready_d  = ready_q;
    ws_load  = ale_fall & bank_hit & (ws_q != 4'd0);
    case (state_q)
      ST_IDLE: begin
        if (ws_load) begin
          ws_cnt_d = ws_q;
          ready_d  = 1'b0;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ready_d = 1'b0;
        if (ws_load) begin
          ws_cnt_d = ws_q;
        end else begin
          ws_cnt_d = ws_cnt_q - 4'd1;
          if (ws_cnt_q == 4'd1) begin
            ready_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign READY = ready_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      wr_sync_q  <= 3'b111;
      ale_sync_q <= 3'b000;
      for (int i = 0; i < NUM_WINDOWS; i++) bank_q[i] <= BANK_BITS'(i);
      ws_q       <= DEFAULT_WS;
      map_en_q   <= 1'b0;
      ws_cnt_q   <= 4'd0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_sync_q  <= wr_sync_d;
      ale_sync_q <= ale_sync_d;
      bank_q     <= bank_d;
      ws_q       <= ws_d;
      map_en_q   <= map_en_d;
      ws_cnt_q   <= ws_cnt_d;
      ready_q    <= ready_d;
    end
  end

`ifdef CHIPSET_READBACK_EN
  logic [7:0] data_out_q, data_out_d;
  logic       data_oe_q, data_oe_d;

  always_comb begin
    data_out_d = 8'hFF;
    for (int i = 0; i < NUM_WINDOWS; i++) begin
      if (offset == 3'(i)) data_out_d = 8'(bank_q[i]);
    end
    if (offset == OFF_WS)   data_out_d = {4'h0, ws_q};
    if (offset == OFF_CTRL) data_out_d = {7'h0, map_en_q};
    data_oe_d = reg_sel & ~RD;
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      data_out_q <= 8'h00;
      data_oe_q  <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
    end
  end

  assign DATA_OUT = data_out_q;
  assign DATA_OE  = data_oe_q;
`else
  logic unused_rd;
  assign unused_rd = RD;
  assign DATA_OUT  = 8'hFF;
  assign DATA_OE   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_chipset_bank_ctrl.sv
//------------------------------------------------------------------------------
// tb_chipset_bank_ctrl : scoreboard bench for chipset_bank_ctrl.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_chipset_bank_ctrl;

  localparam logic [9:0] IO_BASE = 10'h030;
`ifdef CHIPSET_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET_N;
  logic [19:0] ADDR;
  logic        M_IO, RD, WR, ALE;
  logic [7:0]  DATA_IN;
  logic [7:0]  DATA_OUT;
  logic        DATA_OE;
  logic [21:0] PHYS_ADDR;
  logic        BANK_HIT;
  logic        READY;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  rd_q[$];
  logic [22:0] xl_q[$];
  int          rdy_q[$];

  logic [5:0]  bank_m [4];
  logic [3:0]  ws_m;
  logic        map_m;

  always #8 clk = ~clk;

  chipset_bank_ctrl #(
    .IO_BASE(10'h030), .NUM_WINDOWS(4), .WIN_BITS(16),
    .WIN_BASE(20'h80000), .BANK_BITS(6), .DEFAULT_WS(4'd0)
  ) dut (
    .clk(clk), .RESET_N(RESET_N), .ADDR(ADDR), .M_IO(M_IO), .RD(RD), .WR(WR),
    .ALE(ALE), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .PHYS_ADDR(PHYS_ADDR), .BANK_HIT(BANK_HIT), .READY(READY)
  );

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) bank_m[i] = 6'(i);
    ws_m  = 4'd0;
    map_m = 1'b0;
  endfunction

  function automatic logic [7:0] exp_read(input logic [2:0] off);
    if (!RB)          return 8'hFF;
    if (off < 3'd4)   return {2'b00, bank_m[off[1:0]]};
    if (off == 3'd4)  return {4'h0, ws_m};
    if (off == 3'd5)  return {7'h0, map_m};
    return 8'hFF;
  endfunction

  task automatic do_write(input logic [2:0] off, input logic [7:0] data);
    @(negedge clk);
    M_IO = 1'b0; ADDR = 20'(IO_BASE) | 20'(off); DATA_IN = data; WR = 1'b0;
    repeat (4) @(negedge clk);
    WR = 1'b1;
    repeat (4) @(negedge clk);
    if (off < 3'd4)  bank_m[off[1:0]] = data[5:0];
    if (off == 3'd4) ws_m = data[3:0];
    if (off == 3'd5) map_m = data[0];
  endtask

  task automatic do_read(input logic [2:0] off);
    logic [7:0] exp;
    @(negedge clk);
    M_IO = 1'b0; ADDR = 20'(IO_BASE) | 20'(off); RD = 1'b0;
    rd_q.push_back(exp_read(off));
    @(negedge clk);
    exp = rd_q.pop_front();
    checks++;
    if (DATA_OE !== RB) begin
      failures++;
      $display("FAIL read_oe off=%0d: got %b expected %b", off, DATA_OE, RB);
    end
    checks++;
    if (DATA_OUT !== exp) begin
      failures++;
      $display("FAIL read_data off=%0d: got %h expected %h", off, DATA_OUT, exp);
    end
    RD = 1'b1;
  endtask

  task automatic check_xlate(input logic [19:0] addr, input logic mio,
                             input logic exp_hit, input logic [21:0] exp_phys);
    logic [22:0] exp;
    @(negedge clk);
    M_IO = mio; ADDR = addr;
    xl_q.push_back({exp_hit, exp_phys});
    #1;
    exp = xl_q.pop_front();
    checks++;
    if ({BANK_HIT, PHYS_ADDR} !== exp) begin
      failures++;
      $display("FAIL xlate addr=%h: got hit=%b phys=%h expected hit=%b phys=%h",
               addr, BANK_HIT, PHYS_ADDR, exp[22], exp[21:0]);
    end
  endtask

  // Drives ALE from pattern bit i on successive falling edges and measures READY.
  task automatic ale_seq(input logic [19:0] addr, input logic [7:0] pattern, input int exp_low);
    int lows, drops, exp;
    logic prev;
    @(negedge clk);
    M_IO = 1'b1; ADDR = addr; ALE = 1'b0;
    rdy_q.push_back(exp_low);
    lows = 0; drops = 0; prev = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (READY === 1'b0) lows++;
      if (prev === 1'b1 && READY !== 1'b1) drops++;
      prev = READY;
      ALE = (i < 8) ? pattern[i] : 1'b0;
    end
    exp = rdy_q.pop_front();
    checks++;
    if (lows != exp) begin
      failures++;
      $display("FAIL ready_low addr=%h: got %0d clk expected %0d clk", addr, lows, exp);
    end
    checks++;
    if (drops != ((exp > 0) ? 1 : 0)) begin
      failures++;
      $display("FAIL ready_drops addr=%h: got %0d expected %0d", addr, drops, (exp > 0) ? 1 : 0);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; ADDR = 20'h0; M_IO = 1'b0; RD = 1'b1; WR = 1'b1; ALE = 1'b0;
    DATA_IN = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", READY); end
    checks++;
    if (DATA_OE !== 1'b0) begin failures++; $display("FAIL reset_oe: got %b expected 0", DATA_OE); end
    checks++;
    if (DATA_OUT !== (RB ? 8'h00 : 8'hFF)) begin
      failures++; $display("FAIL reset_dout: got %h expected %h", DATA_OUT, RB ? 8'h00 : 8'hFF);
    end
    checks++;
    if ({BANK_HIT, PHYS_ADDR} !== 23'h0) begin
      failures++; $display("FAIL reset_xlate: got hit=%b phys=%h expected 0/0", BANK_HIT, PHYS_ADDR);
    end
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) do_read(3'(i));
  endtask

  task automatic test_translate();
    do_write(3'd1, 8'hEA);
    do_write(3'd5, 8'h01);
    do_read(3'd1);
    do_read(3'd5);
    check_xlate(20'h9ABCD, 1'b1, 1'b1, 22'h2AABCD);
    check_xlate(20'hC0000, 1'b1, 1'b0, 22'h0C0000);
    check_xlate(20'h7FFFF, 1'b1, 1'b0, 22'h07FFFF);
    check_xlate(20'h80000, 1'b1, 1'b1, 22'h000000);
    check_xlate(20'hBFFFF, 1'b1, 1'b1, 22'h03FFFF);
    check_xlate(20'h9ABCD, 1'b0, 1'b0, 22'h09ABCD);
  endtask

  task automatic test_wait_states();
    do_write(3'd4, 8'hF3);
    do_read(3'd4);
    ale_seq(20'h80010, 8'b0000_0001, 3);
    ale_seq(20'h10000, 8'b0000_0001, 0);
    do_write(3'd4, 8'h00);
    ale_seq(20'h80010, 8'b0000_0001, 0);
  endtask

  task automatic test_long_strobe();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h15;
    @(negedge clk);
    M_IO = 1'b0; ADDR = 20'(IO_BASE); DATA_IN = vals[0]; WR = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      DATA_IN = (i < 4) ? vals[i] : 8'h3C;
    end
    @(negedge clk);
    WR = 1'b1;
    repeat (4) @(negedge clk);
    bank_m[0] = 6'h33;
    check_xlate(20'h80123, 1'b1, 1'b1, 22'h330123);
    do_read(3'd0);
  endtask

  task automatic test_back_to_back();
    do_write(3'd4, 8'h02);
    ale_seq(20'h80010, 8'b0000_0001, 2);
    ale_seq(20'h80010, 8'b0000_0101, 4);
  endtask

  task automatic test_async_reset();
    bit seen;
    do_write(3'd4, 8'h05);
    @(negedge clk);
    M_IO = 1'b1; ADDR = 20'h80010; ALE = 1'b1;
    @(negedge clk);
    ALE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (READY === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL wait_entry: got READY=%b expected 0 within 10 clk", READY); end
    #2 RESET_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL async_ready: got %b expected 1", READY); end
    checks++;
    if ({BANK_HIT, PHYS_ADDR} !== {1'b0, 22'h080010}) begin
      failures++; $display("FAIL async_xlate: got hit=%b phys=%h expected 0/080010", BANK_HIT, PHYS_ADDR);
    end
    repeat (2) @(negedge clk);
    RESET_N = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) do_read(3'(i));
    ale_seq(20'h80010, 8'b0000_0001, 0);
    do_write(3'd5, 8'h01);
    check_xlate(20'h9ABCD, 1'b1, 1'b1, 22'h01ABCD);
    check_xlate(20'hBFFFF, 1'b1, 1'b1, 22'h03FFFF);
  endtask

  initial begin
    test_reset();
    test_translate();
    test_wait_states();
    test_long_strobe();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
